axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 The module SHALL have these parameters, one per line: name, default, meaning.
- ADDR_W, 32, address width.
- DATA_W, 32, read-data width.
REQ-002 The module SHALL have these ports, one per line: name, direction, width, meaning. Index 0 = IFU, index 1 = LSU.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m_arvalid  in  2  per-master read-address valid.
- m_arready  out  2  per-master read-address ready.
- m_araddr  in  2*ADDR_W  per-master address; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_rvalid  out  2  per-master read-data valid.
- m_rready  in  2  per-master read-data ready.
- m_rdata  out  2*DATA_W  per-master read data, same slicing as m_araddr.
- m_rresp  out  4  per-master response, 2 bits each.
- s_arvalid  out  1  read-address valid to the shared memory slave.
- s_arready  in  1  slave address ready.
- s_araddr  out  ADDR_W  address to the slave.
- s_rvalid  in  1  slave data valid.
- s_rready  out  1  data ready to the slave.
- s_rdata  in  DATA_W  slave data.
- s_rresp  in  2  slave response.
REQ-003 The write channel SHALL be out of scope; the LSU write path connects to the slave directly.

Function
REQ-004 The module SHALL implement a one-hot FSM with states IDLE, ADDR and DATA, and SHALL allow at most one outstanding slave transaction.
REQ-005 In IDLE, if any m_arvalid is set, the module SHALL pick a winner per REQ-011/012 and assert m_arready for the winner only, combinationally, in the same cycle.
REQ-006 On the winner's AR handshake, the module SHALL register the grant index and m_araddr slice, then move to ADDR on the next edge.
REQ-007 In ADDR, the module SHALL drive s_arvalid=1 and s_araddr = the latched address, and SHALL hold both stable until s_arready; on s_arvalid & s_arready it SHALL move to DATA.
REQ-008 In DATA, the module SHALL forward s_rvalid, s_rdata and s_rresp to the granted master's slice, and SHALL drive s_rready = m_rready of the granted master; the non-granted m_rvalid SHALL be 0 and its m_rdata/m_rresp SHALL be 0.
REQ-009 On s_rvalid & s_rready in DATA, the module SHALL return to IDLE; the next grant SHALL be possible in that IDLE cycle.
REQ-010 Latency from the master AR handshake (cycle N) to s_arvalid SHALL be 1 cycle (asserted in N+1); minimum request-to-request spacing SHALL be 3 cycles.
REQ-011 Outside IDLE, m_arready SHALL be 2'b00; a master's arvalid held during a busy period SHALL be served later, never dropped.
REQ-012 Simultaneous m_arvalid=2'b11 in IDLE SHALL grant exactly one master per REQ-017/018.

Reset
REQ-013 While rst=0, the module SHALL force state to IDLE, the grant register and priority pointer to 0, and the latched address to 0.
REQ-014 During reset, all outputs SHALL be 0: m_arready, m_rvalid, m_rdata, m_rresp, s_arvalid, s_araddr, s_rready.
REQ-015 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no response delivered to any master.
REQ-016 After rst deasserts, the first grant SHALL be possible in the first clock cycle.

Configuration
REQ-017 With ARB_ROUND_ROBIN_EN defined, a 1-bit priority pointer SHALL favour the master it indexes on a tie, and SHALL be set to the non-granted index at each DATA completion.
REQ-018 Without ARB_ROUND_ROBIN_EN, ties SHALL always grant master 1 (LSU), and the pointer SHALL not exist.

Verification
REQ-019 Single IFU read: m_arvalid=01, addr 0x80000000; slave arready=1, rvalid 1 cycle later with data 0xDEADBEEF -> s_araddr=0x80000000 in N+1, m_rdata[31:0]=0xDEADBEEF with m_rvalid=01, FSM back in IDLE.
REQ-020 Tie without macro: m_arvalid=11 repeated 4 times -> all 4 grants go to LSU while LSU stays valid; IFU served only after LSU drops.
REQ-021 Tie with ARB_ROUND_ROBIN_EN: m_arvalid=11 held for 4 transactions -> grants alternate 0,1,0,1.
REQ-022 Backpressure: s_arready=0 for 3 cycles, then m_rready=0 for 2 cycles while s_rvalid=1 -> s_arvalid/s_araddr stable throughout, s_rready=0 until m_rready rises, exactly one completion.
REQ-023 Reset in DATA: drive rst=0 while s_rvalid=0 -> all outputs 0 asynchronously; after release, a new IFU request completes normally with the correct data.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-address/read-data arbiter onto one slave port, one transaction in flight; AR-to-slave latency 1 cycle.
// Stalls on s_arready/m_rready; ties favour LSU, or alternate when ARB_ROUND_ROBIN_EN is defined.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            m_arvalid,
  output logic [1:0]            m_arready,
  input  logic [2*ADDR_W-1:0]   m_araddr,
  output logic [1:0]            m_rvalid,
  input  logic [1:0]            m_rready,
  output logic [2*DATA_W-1:0]   m_rdata,
  output logic [3:0]            m_rresp,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    ADDR = 3'b010,
    DATA = 3'b100
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                win;
  logic                tie_pick;
  logic                ar_hs;
  logic                rd_done;
  logic [ADDR_W-1:0]   win_addr;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else if (rd_done) begin
      ptr_q <= ~gnt_q;
    end
  end

  assign tie_pick = ptr_q;
`else
  assign tie_pick = 1'b1;
`endif

  always_comb begin
    win = 1'b0;
    case (m_arvalid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = tie_pick;
      default: win = 1'b0;
    endcase
  end

  assign win_addr = win ? m_araddr[ADDR_W +: ADDR_W] : m_araddr[0 +: ADDR_W];
  assign ar_hs    = |m_arready;
  assign rd_done  = (state_q == DATA) && s_rvalid && s_rready;

  // m_arready is gated by rst so nothing leaks out while reset is held
  always_comb begin
    state_d   = state_q;
    m_arready = 2'b00;
    m_rvalid  = 2'b00;
    m_rdata   = '0;
    m_rresp   = 4'b0000;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_rready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst && (|m_arvalid)) begin
          m_arready[win] = 1'b1;
          state_d        = ADDR;
        end
      end
      ADDR: begin
        s_arvalid = 1'b1;
        s_araddr  = addr_q;
        if (s_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        s_rready        = m_rready[gnt_q];
        m_rvalid[gnt_q] = s_rvalid;
        if (gnt_q) begin
          m_rdata[DATA_W +: DATA_W] = s_rdata;
          m_rresp[3:2]              = s_rresp;
        end else begin
          m_rdata[0 +: DATA_W] = s_rdata;
          m_rresp[1:0]         = s_rresp;
        end
        if (s_rvalid && m_rready[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        gnt_q  <= win;
        addr_q <= win_addr;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised bench for axi_rd_arbiter against a transaction-level arbitration model.
module tb_axi_rd_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  m_arvalid, m_arready;
  logic [63:0] m_araddr;
  logic [1:0]  m_rvalid, m_rready;
  logic [63:0] m_rdata;
  logic [3:0]  m_rresp;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  int errors = 0;
  int checks = 0;

  // model: a tie goes to the master the pointer names (LSU when pointer is absent);
  // after each completion the pointer names the master that was not served
  bit mdl_ptr = 1'b0;

  logic [1:0]  o_arready, o_rvalid, o_rresp;
  logic [31:0] o_first_addr, o_rdata;
  bit          o_arv_first, o_addr_stable, o_busy_bad, o_rready_bad, o_rvalid_bad;
  bit          o_other_zero, o_idle_after;
  int          o_compl;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit mdl_pick(input logic [1:0] req);
    if (req == 2'b01) return 1'b0;
    if (req == 2'b10) return 1'b1;
    return RR_EN ? mdl_ptr : 1'b1;
  endfunction

  task automatic mdl_done(input bit g);
    mdl_ptr = ~g;
  endtask

  task automatic zero_inputs();
    m_arvalid = 2'b00; m_araddr = '0; m_rready = 2'b00;
    s_arready = 1'b0;  s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    zero_inputs();
    @(negedge clk);
    rst = 1'b1;
    mdl_ptr = 1'b0;
  endtask

  // Drives one transaction from IDLE and records what the DUT did; starts just after a negedge.
  task automatic run_txn(input logic [1:0] req, input bit exp_gnt,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d, input logic [1:0] resp,
                         input int ar_wait, input int r_wait, input int mr_wait);
    logic [1:0] exp_rv;
    bit rdy;
    m_arvalid = req;
    m_araddr  = {a1, a0};
    #1;
    o_arready = m_arready;
    @(negedge clk);
    m_arvalid = req & ~(2'b01 << exp_gnt);
    o_addr_stable = 1'b1; o_busy_bad = 1'b0;
    for (int c = 0; c <= ar_wait; c++) begin
      s_arready = (c == ar_wait);
      #1;
      if (c == 0) begin
        o_arv_first  = s_arvalid;
        o_first_addr = s_araddr;
      end
      if (s_arvalid !== 1'b1 || s_araddr !== o_first_addr) o_addr_stable = 1'b0;
      if (m_arready !== 2'b00) o_busy_bad = 1'b1;
      @(negedge clk);
    end
    s_arready = 1'b0;
    o_compl = 0; o_rready_bad = 1'b0; o_rvalid_bad = 1'b0; o_other_zero = 1'b1;
    o_rdata = '0; o_rresp = 2'b00; o_rvalid = 2'b00;
    for (int c = 0; c <= r_wait + mr_wait; c++) begin
      rdy      = (c >= r_wait + mr_wait);
      s_rvalid = (c >= r_wait);
      s_rdata  = d;
      s_rresp  = resp;
      m_rready = exp_gnt ? {rdy, ~rdy} : {~rdy, rdy};
      #1;
      if (s_rready !== rdy) o_rready_bad = 1'b1;
      if (m_arready !== 2'b00) o_busy_bad = 1'b1;
      exp_rv = s_rvalid ? (2'b01 << exp_gnt) : 2'b00;
      if (m_rvalid !== exp_rv) o_rvalid_bad = 1'b1;
      if (s_rvalid && s_rready) begin
        o_compl++;
        o_rvalid = m_rvalid;
        o_rdata  = exp_gnt ? m_rdata[63:32] : m_rdata[31:0];
        o_rresp  = exp_gnt ? m_rresp[3:2] : m_rresp[1:0];
        if ((exp_gnt ? m_rdata[31:0] : m_rdata[63:32]) !== 32'h0 ||
            (exp_gnt ? m_rresp[1:0] : m_rresp[3:2]) !== 2'b00) o_other_zero = 1'b0;
      end
      @(negedge clk);
    end
    s_rvalid = 1'b0;
    m_rready = 2'b00;
    #1;
    o_idle_after = (s_arvalid === 1'b0) && (m_rvalid === 2'b00) && (s_rready === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m_arvalid = 2'b11; m_araddr = {$urandom, $urandom}; m_rready = 2'b11;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = $urandom; s_rresp = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_arready !== 2'b00) begin errors++; $display("FAIL reset_m_arready: got %b want 00", m_arready); end
    checks++; if (m_rvalid !== 2'b00) begin errors++; $display("FAIL reset_m_rvalid: got %b want 00", m_rvalid); end
    checks++; if (m_rdata !== 64'h0) begin errors++; $display("FAIL reset_m_rdata: got %h want 0", m_rdata); end
    checks++; if (m_rresp !== 4'h0) begin errors++; $display("FAIL reset_m_rresp: got %h want 0", m_rresp); end
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL reset_s_arvalid: got %b want 0", s_arvalid); end
    checks++; if (s_araddr !== 32'h0) begin errors++; $display("FAIL reset_s_araddr: got %h want 0", s_araddr); end
    checks++; if (s_rready !== 1'b0) begin errors++; $display("FAIL reset_s_rready: got %b want 0", s_rready); end
    zero_inputs();
  endtask

  task automatic test_single_ifu();
    @(negedge clk);
    rst = 1'b1;
    mdl_ptr = 1'b0;
    run_txn(2'b01, 1'b0, 32'h8000_0000, $urandom, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    mdl_done(1'b0);
    checks++; if (o_arready !== 2'b01) begin errors++; $display("FAIL ifu_grant: got %b want 01", o_arready); end
    checks++; if (o_arv_first !== 1'b1) begin errors++; $display("FAIL ifu_latency: s_arvalid in N+1 got %b want 1", o_arv_first); end
    checks++; if (o_first_addr !== 32'h8000_0000) begin errors++; $display("FAIL ifu_addr: got %h want 80000000", o_first_addr); end
    checks++; if (o_rvalid !== 2'b01) begin errors++; $display("FAIL ifu_rvalid: got %b want 01", o_rvalid); end
    checks++; if (o_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ifu_rdata: got %h want deadbeef", o_rdata); end
    checks++; if (o_compl !== 1) begin errors++; $display("FAIL ifu_completions: got %0d want 1", o_compl); end
    checks++; if (!o_idle_after || !o_other_zero) begin errors++; $display("FAIL ifu_idle: idle=%0d other_zero=%0d want 1 1", o_idle_after, o_other_zero); end
  endtask

  task automatic test_tie();
    logic [3:0] exp_seq;
    logic [31:0] a0, a1, d;
    pulse_reset();
    exp_seq = RR_EN ? 4'b1010 : 4'b1111;
    for (int i = 0; i < 4; i++) begin
      a0 = $urandom; a1 = $urandom; d = $urandom;
      run_txn(2'b11, exp_seq[i], a0, a1, d, 2'b01, $urandom_range(1), $urandom_range(1), 0);
      mdl_done(exp_seq[i]);
      checks++;
      if (o_arready !== (2'b01 << exp_seq[i]))
        begin errors++; $display("FAIL tie_grant%0d: got %b want %b", i, o_arready, 2'b01 << exp_seq[i]); end
      checks++;
      if (o_first_addr !== (exp_seq[i] ? a1 : a0) || o_rdata !== d)
        begin errors++; $display("FAIL tie_data%0d: addr %h data %h want addr %h data %h", i, o_first_addr, o_rdata, exp_seq[i] ? a1 : a0, d); end
    end
    a0 = $urandom; d = $urandom;
    run_txn(2'b01, 1'b0, a0, $urandom, d, 2'b00, 0, 0, 0);
    mdl_done(1'b0);
    checks++; if (o_arready !== 2'b01 || o_rdata !== d) begin errors++; $display("FAIL tie_ifu_after: grant %b data %h want 01 %h", o_arready, o_rdata, d); end
    m_arvalid = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, d;
    a1 = $urandom; d = $urandom;
    run_txn(2'b10, 1'b1, $urandom, a1, d, 2'b10, 3, 0, 2);
    mdl_done(1'b1);
    checks++; if (!o_addr_stable || !o_arv_first || o_first_addr !== a1) begin errors++; $display("FAIL bp_addr_stable: stable=%0d addr %h want 1 %h", o_addr_stable, o_first_addr, a1); end
    checks++; if (o_rready_bad) begin errors++; $display("FAIL bp_s_rready: followed m_rready got 0 want 1"); end
    checks++; if (o_rvalid_bad || o_busy_bad) begin errors++; $display("FAIL bp_channel: rvalid_bad=%0d busy_arready=%0d want 0 0", o_rvalid_bad, o_busy_bad); end
    checks++; if (o_compl !== 1 || o_rdata !== d || o_rresp !== 2'b10) begin errors++; $display("FAIL bp_completion: n=%0d data %h resp %b want 1 %h 10", o_compl, o_rdata, o_rresp, d); end
    m_arvalid = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [1:0] req, carry;
    logic [31:0] a0, a1, d;
    logic [1:0] resp;
    bit g;
    carry = 2'b00;
    for (int i = 0; i < 24; i++) begin
      req = 2'($urandom_range(3, 1)) | carry;
      g = mdl_pick(req);
      a0 = $urandom; a1 = $urandom; d = $urandom; resp = 2'($urandom);
      run_txn(req, g, a0, a1, d, resp, $urandom_range(2), $urandom_range(2), $urandom_range(2));
      mdl_done(g);
      carry = req & ~(2'b01 << g);
      checks++;
      if (o_arready !== (2'b01 << g))
        begin errors++; $display("FAIL b2b_grant%0d: req %b got %b want %b", i, req, o_arready, 2'b01 << g); end
      checks++;
      if (o_first_addr !== (g ? a1 : a0) || o_rdata !== d || o_rresp !== resp || o_compl !== 1)
        begin errors++; $display("FAIL b2b_xfer%0d: addr %h data %h resp %b n=%0d want %h %h %b 1", i, o_first_addr, o_rdata, o_rresp, o_compl, g ? a1 : a0, d, resp); end
      checks++;
      if (!o_addr_stable || !o_arv_first || o_busy_bad || o_rready_bad || o_rvalid_bad || !o_other_zero || !o_idle_after)
        begin errors++; $display("FAIL b2b_protocol%0d: stable=%0d first=%0d busy=%0d rrdy=%0d rv=%0d oz=%0d idle=%0d", i, o_addr_stable, o_arv_first, o_busy_bad, o_rready_bad, o_rvalid_bad, o_other_zero, o_idle_after); end
    end
    m_arvalid = 2'b00;
  endtask

  task automatic test_reset_in_data();
    logic [31:0] d;
    @(negedge clk);
    m_arvalid = 2'b01; m_araddr = {$urandom, $urandom};
    @(negedge clk);
    m_arvalid = 2'b00; s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b0; m_rready = 2'b01;
    #1;
    checks++; if (s_rready !== 1'b1) begin errors++; $display("FAIL rstdata_in_data: s_rready got %b want 1", s_rready); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (m_arready !== 2'b00 || m_rvalid !== 2'b00 || m_rdata !== 64'h0 || m_rresp !== 4'h0 ||
        s_arvalid !== 1'b0 || s_araddr !== 32'h0 || s_rready !== 1'b0)
      begin errors++; $display("FAIL rstdata_async: arrdy %b rv %b rd %h rr %h sav %b sad %h srr %b want all 0", m_arready, m_rvalid, m_rdata, m_rresp, s_arvalid, s_araddr, s_rready); end
    s_rvalid = 1'b1; s_rdata = $urandom; m_rready = 2'b11; m_arvalid = 2'b11;
    #1;
    checks++; if (m_rvalid !== 2'b00 || m_arready !== 2'b00) begin errors++; $display("FAIL rstdata_no_resp: rvalid %b arready %b want 00 00", m_rvalid, m_arready); end
    @(negedge clk);
    zero_inputs();
    rst = 1'b1;
    mdl_ptr = 1'b0;
    d = $urandom;
    run_txn(2'b01, 1'b0, 32'h0000_1000, $urandom, d, 2'b00, 0, 1, 0);
    mdl_done(1'b0);
    checks++; if (o_arready !== 2'b01 || o_first_addr !== 32'h0000_1000) begin errors++; $display("FAIL rstdata_regrant: grant %b addr %h want 01 00001000", o_arready, o_first_addr); end
    checks++; if (o_rdata !== d || o_compl !== 1 || !o_idle_after) begin errors++; $display("FAIL rstdata_after: data %h n=%0d idle=%0d want %h 1 1", o_rdata, o_compl, o_idle_after, d); end
  endtask

  initial begin
    rst = 1'b0;
    zero_inputs();
    test_reset();
    test_single_ifu();
    test_tie();
    test_backpressure();
    test_back_to_back();
    test_reset_in_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
